// File: rtl/framed_debug_serializer_pkg.sv
// Shared definitions for the framed debug serializer: frame state encoding,
// default sync header and the checksum fold helper.
package debug_frame_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA5C3;
    localparam int          CHECKSUM_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } frame_state_e;

    function automatic logic [CHECKSUM_W-1:0] checksum_update(
        input logic [CHECKSUM_W-1:0] acc,
        input logic [CHECKSUM_W-1:0] word
    );
        return acc ^ word;
    endfunction

endpackage

// File: rtl/framed_debug_serializer_if.sv
// Debug read/serial bundle between the serializer (master: issues fetches,
// drives the stream) and the SRAM/capture side (slave).
interface framed_debug_serializer_if #(
    parameter int FETCH_WIDTH = 16
);
    logic                   en;
    logic [FETCH_WIDTH-1:0] parallel_data;
    logic                   fetch_req;
    logic                   serial_data;
    logic                   out_valid;
    logic                   frame_done;

    modport master (
        input  en,
        input  parallel_data,
        output fetch_req,
        output serial_data,
        output out_valid,
        output frame_done
    );

    modport slave (
        output en,
        output parallel_data,
        input  fetch_req,
        input  serial_data,
        input  out_valid,
        input  frame_done
    );
endinterface

// File: rtl/framed_debug_serializer_shift_out_reg.sv
// Load/shift register emitting its LSB; load has priority over shift.
module shift_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tap
);
    logic [WIDTH-1:0] r_data;

    // Shift register: parallel load or right shift toward the tap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_val;
        end else if (i_shift) begin
            r_data <= {1'b0, r_data[WIDTH-1:1]};
        end else begin
            r_data <= r_data;
        end
    end

    assign o_tap = r_data[0];
endmodule

// File: rtl/framed_debug_serializer.sv
// Pulls NUM_WORDS words through a fixed-latency fetch handshake and emits
// sync header, data words and XOR checksum as one gap-free LSB-first stream.
module framed_debug_serializer
    import debug_frame_pkg::*;
#(
    parameter int          FETCH_WIDTH  = 16,
    parameter int          NUM_WORDS    = 4096,
    parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
    parameter int          READ_LATENCY = 1
) (
    input logic                        clk,
    input logic                        rst_n,
    framed_debug_serializer_if.master  bus
);
    localparam int                    WORD_CNT_W    = $clog2(NUM_WORDS + 1);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD     = WORD_CNT_W'(NUM_WORDS - 1);
    // fetch_req is registered, so it is decided one bit before it must show
    localparam logic [3:0]            PRE_FETCH_BIT = 4'(14 - READ_LATENCY);

    frame_state_e            r_state;
    frame_state_e            w_state_nxt;
    logic [3:0]              r_bit_cnt;
    logic [WORD_CNT_W-1:0]   r_word_cnt;
    logic [FETCH_WIDTH-1:0]  r_prefetch;
    logic [CHECKSUM_W-1:0]   r_checksum;
    logic                    r_fetch_pending;
    logic                    r_fetch_req;
    logic                    r_out_valid;
    logic                    r_frame_done;

    logic                    w_wrap;
    logic                    w_last_word;
    logic                    w_capture;
    logic [FETCH_WIDTH-1:0]  w_next_word;
    logic [FETCH_WIDTH-1:0]  w_load_val;
    logic                    w_load;
    logic                    w_shift;
    logic                    w_fetch_req_nxt;
    logic                    w_out_valid_nxt;
    logic                    w_frame_done_nxt;
    logic                    w_serial;

    assign w_wrap      = (r_bit_cnt == 4'd15);
    assign w_last_word = (r_word_cnt == LAST_WORD);
    // Read data lands exactly on the word boundary, so it bypasses the prefetch register
    assign w_capture   = r_fetch_pending & w_wrap & bus.en;
    assign w_next_word = w_capture ? bus.parallel_data : r_prefetch;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; en low aborts from any state
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_HEADER;
                ST_HEADER: w_state_nxt = w_wrap ? ST_DATA : ST_HEADER;
                ST_DATA:   w_state_nxt = (w_wrap && w_last_word) ? ST_CHECK : ST_DATA;
                ST_CHECK:  w_state_nxt = w_wrap ? ST_DONE : ST_CHECK;
                ST_DONE:   w_state_nxt = ST_DONE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output decode: shifter control and next values of the registered outputs
    always_comb begin
        w_out_valid_nxt  = (w_state_nxt == ST_HEADER) || (w_state_nxt == ST_DATA) ||
                           (w_state_nxt == ST_CHECK);
        w_frame_done_nxt = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
        w_fetch_req_nxt  = 1'b0;
        w_load           = 1'b0;
        w_shift          = 1'b0;
        w_load_val       = '0;
        if (!bus.en) begin
            w_load = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_load     = 1'b1;
                    w_load_val = SYNC_WORD;
                end
                ST_HEADER: begin
                    w_fetch_req_nxt = (r_bit_cnt == PRE_FETCH_BIT);
                    if (w_wrap) begin
                        w_load     = 1'b1;
                        w_load_val = w_next_word;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_fetch_req_nxt = (r_bit_cnt == PRE_FETCH_BIT) && !w_last_word;
                    if (w_wrap) begin
                        w_load     = 1'b1;
                        w_load_val = w_last_word ? r_checksum : w_next_word;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_wrap) begin
                        w_load = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
                ST_DONE: w_load = 1'b0;
                default: w_load = 1'b1;
            endcase
        end
    end

    // Registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_fetch_req  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_fetch_req  <= w_fetch_req_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Counters, prefetch capture and running checksum; all cleared on return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt       <= 4'd0;
            r_word_cnt      <= '0;
            r_prefetch      <= '0;
            r_checksum      <= '0;
            r_fetch_pending <= 1'b0;
        end else if (w_state_nxt == ST_IDLE) begin
            r_bit_cnt       <= 4'd0;
            r_word_cnt      <= '0;
            r_prefetch      <= '0;
            r_checksum      <= '0;
            r_fetch_pending <= 1'b0;
        end else begin
            r_bit_cnt  <= ((r_state == ST_IDLE) || (w_state_nxt == ST_DONE)) ?
                          4'd0 : r_bit_cnt + 4'd1;
            r_word_cnt <= ((r_state == ST_DATA) && w_wrap && !w_last_word) ?
                          r_word_cnt + WORD_CNT_W'(1) : r_word_cnt;
            if (w_capture) begin
                r_prefetch      <= bus.parallel_data;
                r_checksum      <= checksum_update(r_checksum, bus.parallel_data);
                r_fetch_pending <= 1'b0;
            end else begin
                r_prefetch      <= r_prefetch;
                r_checksum      <= r_checksum;
                r_fetch_pending <= r_fetch_pending | r_fetch_req;
            end
        end
    end

    shift_out_reg #(
        .WIDTH (FETCH_WIDTH)
    ) u_shift_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_load_val (w_load_val),
        .o_tap      (w_serial)
    );

    assign bus.serial_data = w_serial;
    assign bus.out_valid   = r_out_valid;
    assign bus.fetch_req   = r_fetch_req;
    assign bus.frame_done  = r_frame_done;
endmodule

// File: tb/tb_framed_debug_serializer.sv
// Three serializer lanes (4 words/latency 1, 4 words/latency 3, 4096 words/latency 2)
// driven by a latency-accurate SRAM model; frames are compared against a word-level model.
module tb_framed_debug_serializer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en [3];
    logic [15:0] pd [3];
    logic        fr [3];
    logic        sd [3];
    logic        ov [3];
    logic        fd [3];

    logic [15:0] mem  [3][4096];
    int          ptr  [3];
    logic [15:0] hist [3];

    bit   rx [3][$];
    logic pv [3] = '{1'b0, 1'b0, 1'b0};
    int   fetch_tot [3];
    int   fetch_bad [3];
    int   done_tot  [3];
    int   done_bad  [3];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int rl_of(input int lane);
        return (lane == 0) ? 1 : ((lane == 1) ? 3 : 2);
    endfunction

    function automatic int nw_of(input int lane);
        return (lane == 2) ? 4096 : 4;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int NW = (g == 2) ? 4096 : 4;
        localparam int RL = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        framed_debug_serializer_if #(.FETCH_WIDTH(16)) bus ();
        assign bus.en            = en[g];
        assign bus.parallel_data = pd[g];
        assign fr[g]             = bus.fetch_req;
        assign sd[g]             = bus.serial_data;
        assign ov[g]             = bus.out_valid;
        assign fd[g]             = bus.frame_done;
        framed_debug_serializer #(
            .FETCH_WIDTH  (16),
            .NUM_WORDS    (NW),
            .SYNC_WORD    (16'hA5C3),
            .READ_LATENCY (RL)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // SRAM model: word valid only during the cycle READ_LATENCY after the request, garbage otherwise
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n || !en[i]) begin
                ptr[i]  <= 0;
                hist[i] <= 16'h0000;
                pd[i]   <= 16'($urandom);
            end else begin
                hist[i] <= {hist[i][14:0], fr[i]};
                if ((rl_of(i) == 1) ? fr[i] : hist[i][rl_of(i) - 2]) begin
                    pd[i]  <= mem[i][ptr[i] % 4096];
                    ptr[i] <= ptr[i] + 1;
                end else begin
                    pd[i] <= 16'($urandom);
                end
            end
        end
    end

    // Stream monitor: collects frame bits, fetch positions and frame_done placement
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            pv[i] <= ov[i];
            if (ov[i] === 1'b1) begin
                if (pv[i] !== 1'b1) rx[i].delete();
                rx[i].push_back(sd[i]);
            end
            if (fr[i] === 1'b1) begin
                fetch_tot[i] <= fetch_tot[i] + 1;
                if (ov[i] !== 1'b1 || ((int'(rx[i].size()) - 1) % 16) != 15 - rl_of(i))
                    fetch_bad[i] <= fetch_bad[i] + 1;
            end
            if (fd[i] === 1'b1) begin
                done_tot[i] <= done_tot[i] + 1;
                if (pv[i] !== 1'b1 || ov[i] !== 1'b0) done_bad[i] <= done_bad[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int lane, input int base, input int limit);
        int n;
        n = 0;
        while (done_tot[lane] == base && n < limit) begin
            tick();
            n++;
        end
        check(tag, done_tot[lane] - base, 1);
    endtask

    task automatic wait_bits(input string tag, input int lane, input int nbits, input int limit);
        int n;
        n = 0;
        while (int'(rx[lane].size()) != nbits && n < limit) begin
            tick();
            n++;
        end
        check(tag, rx[lane].size(), nbits);
    endtask

    // Expected frame: sync word, every data word, then XOR of all words, each LSB first
    task automatic check_frame(input string tag, input int lane, output logic [15:0] rx_ck);
        logic [15:0] x;
        logic [15:0] w;
        int nw;
        int bad;
        nw    = nw_of(lane);
        x     = 16'h0000;
        rx_ck = 16'h0000;
        for (int k = 0; k < nw; k++) x = x ^ mem[lane][k];
        check({tag, "_len"}, rx[lane].size(), 16 * (nw + 2));
        bad = 0;
        for (int k = 0; k < 16 * (nw + 2); k++) begin
            if (k < 16) w = 16'hA5C3;
            else if (k < 16 * (nw + 1)) w = mem[lane][k / 16 - 1];
            else w = x;
            if (k >= int'(rx[lane].size())) bad++;
            else if (rx[lane][k] != w[k % 16]) bad++;
        end
        check({tag, "_bits"}, bad, 0);
        if (int'(rx[lane].size()) == 16 * (nw + 2)) begin
            for (int b = 0; b < 16; b++) rx_ck[b] = rx[lane][16 * (nw + 1) + b];
        end
        check({tag, "_cksum"}, rx_ck, x);
    endtask

    initial begin
        logic [15:0] ck;
        int b0;
        int b1;
        int b2;
        int cnt;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) en[i] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem[i][0] = 16'h0001;
            mem[i][1] = 16'h8000;
            mem[i][2] = 16'hFFFF;
            mem[i][3] = 16'h1234;
        end
        for (int k = 0; k < 4096; k++) mem[2][k] = 16'($urandom);

        repeat (3) tick();
        check("rst_out_valid", ov[0], 1'b0);
        check("rst_serial", sd[0], 1'b0);
        check("rst_fetch_req", fr[0], 1'b0);
        check("rst_frame_done", fd[0], 1'b0);

        rst_n = 1'b1;
        tick();
        b0 = done_tot[0];
        b1 = done_tot[1];
        en[0] = 1'b1;
        en[1] = 1'b1;
        wait_done("rl1_done", 0, b0, 300);
        wait_done("rl3_done", 1, b1, 300);
        check_frame("rl1", 0, ck);
        check("rl1_cksum_6dca", ck, 16'h6DCA);
        check_frame("rl3", 1, ck);
        cnt = 0;
        for (int k = 0; k < 96; k++) if (rx[0][k] != rx[1][k]) cnt++;
        check("rl1_vs_rl3_stream", cnt, 0);
        check("rl1_fetches", fetch_tot[0], 4);
        check("rl3_fetches", fetch_tot[1], 4);
        check("rl1_fetch_pos", fetch_bad[0], 0);
        check("rl3_fetch_pos", fetch_bad[1], 0);
        check("rl1_done_pos", done_bad[0], 0);
        check("rl3_done_pos", done_bad[1], 0);

        cnt = 0;
        repeat (50) begin
            tick();
            if (ov[0] !== 1'b0 || fr[0] !== 1'b0) cnt++;
        end
        check("done_hold_quiet", cnt, 0);
        check("done_hold_fetches", fetch_tot[0], 4);
        check("done_hold_single_done", done_tot[0] - b0, 1);

        en[0] = 1'b0;
        en[1] = 1'b0;
        repeat (2) tick();

        en[1] = 1'b1;
        wait_bits("abort_point", 1, 55, 200);
        b1 = done_tot[1];
        en[1] = 1'b0;
        tick();
        check("abort_out_valid", ov[1], 1'b0);
        check("abort_fetch_req", fr[1], 1'b0);
        repeat (3) tick();
        check("abort_no_done", done_tot[1] - b1, 0);
        for (int k = 0; k < 4; k++) mem[1][k] = 16'($urandom);
        en[1] = 1'b1;
        wait_done("restart_done", 1, b1, 300);
        check_frame("restart", 1, ck);
        en[1] = 1'b0;

        en[0] = 1'b1;
        wait_bits("check_point", 0, 87, 300);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", ov[0], 1'b0);
        check("async_rst_serial", sd[0], 1'b0);
        check("async_rst_fetch_req", fr[0], 1'b0);
        check("async_rst_frame_done", fd[0], 1'b0);
        b0 = done_tot[0];
        tick();
        tick();
        rst_n = 1'b1;
        wait_done("post_rst_done", 0, b0, 300);
        check_frame("post_rst", 0, ck);
        check("post_rst_done_pos", done_bad[0], 0);
        check("post_rst_fetch_pos", fetch_bad[0], 0);
        en[0] = 1'b0;

        b2 = done_tot[2];
        en[2] = 1'b1;
        wait_done("big_done", 2, b2, 70000);
        check_frame("big", 2, ck);
        check("big_fetches", fetch_tot[2], 4096);
        check("big_fetch_pos", fetch_bad[2], 0);
        check("big_done_pos", done_bad[2], 0);
        en[2] = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/framed_debug_serializer.md
Name: framed_debug_serializer

Overview:
- Downstream consumer of the output SRAM interfaces' debug read port.
- Pulls NUM_WORDS parallel words through a fetch-request/fixed-latency handshake and emits them as one framed serial stream, LSB first: 16-bit sync header, the data words, then a 16-bit XOR checksum.
- Supersedes the bare serializer on the debug path; the framing lets off-chip capture find word alignment and detect bit errors.

Parameters:
- FETCH_WIDTH, 16, parallel word width (fixed at 16 so header and checksum align to words).
- NUM_WORDS, 4096, data words per frame (2*BANK_DEPTH); must be >= 2.
- SYNC_WORD, 16'hA5C3, frame header value.
- READ_LATENCY, 1, cycles from fetch_req to valid parallel_data; supported values 1..FETCH_WIDTH-2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  level enable; frame runs while high.
- parallel_data  input  FETCH_WIDTH  read data from the SRAM interface.
- fetch_req  output  1  one-cycle pulse requesting the next word; drives the SRAM interface debug_read_trig.
- serial_data  output  1  serial bit, LSB first.
- out_valid  output  1  high while serial_data carries a frame bit.
- frame_done  output  1  one-cycle pulse after the last checksum bit.

Behaviour:
- All outputs are registered.
- Reset values:
  - serial_data=0, out_valid=0, fetch_req=0, frame_done=0.
  - State IDLE; bit counter, word counter, shift register, prefetch register and checksum all 0.
- States: IDLE, HEADER, DATA, CHECK, DONE.
- IDLE:
  - en sampled high at edge k → HEADER.
  - At edge k+1 out_valid=1 and serial_data=SYNC_WORD[0].
  - Shift register loaded with SYNC_WORD.
- Shifting:
  - Each cycle in HEADER/DATA/CHECK emits one bit.
  - Bit index b counts 0..15 per word.
- Prefetch:
  - At b = 15-READ_LATENCY, fetch_req pulses one cycle if another data word remains to be fetched.
  - parallel_data is captured into the prefetch register exactly READ_LATENCY cycles after the fetch_req cycle.
  - The capture XORs the word into the checksum.
- Word transition (b wraps 15→0):
  - HEADER → DATA, loading the prefetched word.
  - DATA → next word, or → CHECK after word NUM_WORDS-1, loading the checksum.
  - CHECK → DONE.
- Stream continuity: no gap cycles; exactly 16*(NUM_WORDS+2) consecutive valid bits.
- Fetch count: exactly NUM_WORDS fetch_req pulses per frame. The first pulse occurs during HEADER; no pulse occurs during the last data word or CHECK.
- Checksum: XOR of all NUM_WORDS words, 16-bit, emitted LSB first.
- DONE:
  - out_valid=0, serial_data=0; frame_done=1 for the first DONE cycle only.
  - Remains in DONE while en high, with no restart.
  - en low → IDLE next edge.
- en deasserted mid-frame (any state):
  - Next edge → IDLE, out_valid=0, fetch_req=0.
  - Counters and checksum cleared; no frame_done.
  - A data word captured in that same cycle is discarded.
- en re-asserted after abort: a fresh frame starts with the header (the SRAM interface read pointer resets on its own debug deassert).
- Async reset mid-frame: immediately forces reset values.
- Counters:
  - Word counter width $clog2(NUM_WORDS+1); compare against NUM_WORDS-1 explicitly, no reliance on wrap.
  - Bit counter 4 bits.

Decomposition:
- Shared package `debug_frame_pkg`: SYNC_WORD default, state enum typedef, checksum width constant.
- One natural sub-module, `shift_out_reg`: a 16-bit load/shift register with LSB tap, instantiated for the output shifter.
- FSM, counters, prefetch and checksum live in the top module.

Test Plan:
- NUM_WORDS=4, words 16'h0001, 16'h8000, 16'hFFFF, 16'h1234, en held high:
  - 96 valid bits: A5C3, the four words, then checksum 16'h6DCA, each LSB first.
  - frame_done pulses once, one cycle after bit 95.
- Same frame against a model SRAM with READ_LATENCY=1 and then 3:
  - Exactly 4 fetch_req pulses, each at b=15-READ_LATENCY.
  - No out_valid gaps; bit stream identical for both latencies.
- en dropped at data word 2, bit 7:
  - out_valid=0 on the next edge, no frame_done.
  - Re-raise en: header A5C3 restarts and the checksum excludes stale words.
- Async rst_n pulse mid-CHECK:
  - Outputs 0 immediately.
  - After release with en high, a full correct frame follows.
- NUM_WORDS=4096 with 4096 random words, bench shadow XOR:
  - 65568 bits, all match.
  - Received checksum equals bench XOR; 4096 fetch pulses.
- en held high after DONE for 50 cycles:
  - No fetch_req, out_valid stays 0, single frame_done.
